// File: rtl/seg7_scan_4digit.sv
// seg7_scan_4digit: frame-latched, time-multiplexed 4-digit 7-segment driver with leading-zero blanking
module seg7_scan_4digit #(
  parameter int DIGIT_CYCLES   = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int CW = DIGIT_CYCLES > 1 ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   frame_bcd_q, frame_bcd_d;
  logic [3:0]    frame_dp_q, frame_dp_d;
  logic          frame_blz_q, frame_blz_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          last, load, blank;
  logic [3:0]    nib, zero, an_hot;
  logic [6:0]    seg_hi;
  always_comb begin
    last        = cnt_q == CNT_LAST;
    load        = cnt_q == '0 && idx_q == 2'd0;
    cnt_d       = last ? '0 : cnt_q + CW'(1);
    idx_d       = last ? idx_q + 2'd1 : idx_q;
    frame_bcd_d = load ? bcd : frame_bcd_q;
    frame_dp_d  = load ? dp_in : frame_dp_q;
    frame_blz_d = load ? blank_lz : frame_blz_q;
    nib         = frame_bcd_q[{idx_q, 2'b00} +: 4];
    zero[3]     = frame_bcd_q[15:12] == 4'd0;
    zero[2]     = zero[3] && frame_bcd_q[11:8] == 4'd0;
    zero[1]     = zero[2] && frame_bcd_q[7:4] == 4'd0;
    zero[0]     = 1'b0;
    blank       = frame_blz_q && zero[idx_q];
    seg_hi      = 7'h40;
    case (nib)
      4'd0: seg_hi = 7'h3F;
      4'd1: seg_hi = 7'h06;
      4'd2: seg_hi = 7'h5B;
      4'd3: seg_hi = 7'h4F;
      4'd4: seg_hi = 7'h66;
      4'd5: seg_hi = 7'h6D;
      4'd6: seg_hi = 7'h7D;
      4'd7: seg_hi = 7'h07;
      4'd8: seg_hi = 7'h7F;
      4'd9: seg_hi = 7'h6F;
      default: seg_hi = 7'h40;
    endcase
    seg_hi      = blank ? 7'h00 : seg_hi;
    an_hot      = 4'b0001 << idx_q;
    seg_d       = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d        = SEG_ACTIVE_LOW ? ~frame_dp_q[idx_q] : frame_dp_q[idx_q];
    an_d        = AN_ACTIVE_LOW ? ~an_hot : an_hot;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      frame_bcd_q <= 16'h0000;
      frame_dp_q  <= 4'h0;
      frame_blz_q <= 1'b0;
      seg_q       <= {7{SEG_ACTIVE_LOW}};
      dp_q        <= SEG_ACTIVE_LOW;
      an_q        <= {4{AN_ACTIVE_LOW}};
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_bcd_q <= frame_bcd_d;
      frame_dp_q  <= frame_dp_d;
      frame_blz_q <= frame_blz_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
endmodule

// File: tb/tb_seg7_scan_4digit.sv
// tb_seg7_scan_4digit: scoreboard bench for the 4-digit scan driver at DIGIT_CYCLES=4 and 1
module tb_seg7_scan_4digit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = 16'h1234;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;
  int          checks = 0;
  int          failures = 0;
  int          e = 0;
  int          r;
  bit          mon_en = 1'b0;
  logic [11:0] q[$];
  logic [11:0] cur = '0;
  logic [3:0]  fast_exp;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  seg7_scan_4digit #(.DIGIT_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg0), .dp(dp0), .an(an0)
  );
  seg7_scan_4digit #(.DIGIT_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg1), .dp(dp1), .an(an1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_frame(input logic [15:0] b, input logic [3:0] d, input logic z);
    logic       blank;
    logic [6:0] s;
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      blank = z && i > 0 && (b >> (4 * i)) == 16'h0;
      s = blank ? 7'h00 : seg_tab[b[4*i +: 4]];
      a = 4'b0001 << i;
      q.push_back({~s, ~d[i], ~a});
    end
  endtask
  task automatic frame(input logic [15:0] b, input logic [3:0] d, input logic z);
    bcd = b;
    dp_in = d;
    blank_lz = z;
    push_frame(b, d, z);
    repeat (16) @(negedge clk);
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) e <= 0;
    else e <= e + 1;
  always @(negedge clk) begin
    if (mon_en && e >= 2) begin
      r = (e - 1) % 16;
      if (r != 0) begin
        if (r % 4 == 0 || r == 1) begin
          if (q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
          else cur = q.pop_front();
        end
        chk("scan", {seg0, dp0, an0}, cur);
      end
    end
  end
  always @(negedge clk) begin
    if (mon_en && e >= 1 && e <= 8) begin
      fast_exp = ~(4'b0001 << ((e - 1) % 4));
      chk("fast_an", an1, fast_exp);
    end
  end
  initial begin
    #12;
    chk("rst_seg", seg0, 7'h7F);
    chk("rst_dp", dp0, 1'b1);
    chk("rst_an", an0, 4'hF);
    chk("rst_an_fast", an1, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    frame(16'h1234, 4'b0000, 1'b0);
    frame(16'h1234, 4'b0000, 1'b0);
    frame(16'h0050, 4'b0100, 1'b1);
    frame(16'h0050, 4'b0000, 1'b0);
    frame(16'h0000, 4'b0100, 1'b1);
    frame(16'h00A0, 4'b0000, 1'b1);
    bcd = 16'h1111;
    dp_in = 4'b0000;
    blank_lz = 1'b0;
    push_frame(16'h1111, 4'b0000, 1'b0);
    repeat (8) @(negedge clk);
    bcd = 16'h2222;
    repeat (8) @(negedge clk);
    frame(16'h2222, 4'b0000, 1'b0);
    frame(16'h0908, 4'b1001, 1'b1);
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", q.size(), 32'd0);
    repeat (13) @(negedge clk);
    chk("pre_rst_an", an0, 4'b0111);
    #1 rst_n = 1'b0;
    #1;
    chk("async_seg", seg0, 7'h7F);
    chk("async_dp", dp0, 1'b1);
    chk("async_an", an0, 4'hF);
    chk("async_an_fast", an1, 4'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
